// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: shared widths, x0 address and FSM state encoding for the writeback arbiter
package regfile_wb_arbiter_pkg;
  localparam int XLEN_DEF = 32;
  localparam int AW_DEF = 5;
  localparam int CNT_W_DEF = 16;
  localparam int X0 = 0;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_A_ONLY = 3'd1;
  localparam logic [2:0] ST_M_ONLY = 3'd2;
  localparam logic [2:0] ST_BOTH_AF = 3'd3;
  localparam logic [2:0] ST_BOTH_MF = 3'd4;
  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    A_ONLY = ST_A_ONLY,
    M_ONLY = ST_M_ONLY,
    BOTH_AF = ST_BOTH_AF,
    BOTH_MF = ST_BOTH_MF
  } state_e;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: ALU/load writeback handshakes, register-file write port and status outputs
interface regfile_wb_arbiter_if
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int AW = AW_DEF,
  parameter int CNT_W = CNT_W_DEF
);
  logic alu_valid;
  logic alu_ready;
  logic [AW-1:0] alu_rd;
  logic [XLEN-1:0] alu_data;
  logic mem_valid;
  logic mem_ready;
  logic [AW-1:0] mem_rd;
  logic [XLEN-1:0] mem_data;
  logic rf_we;
  logic [AW-1:0] rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [(1<<AW)-1:0] pend_mask;
  logic [CNT_W-1:0] conflict_cnt;
  modport slave (
    input alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output alu_ready, mem_ready, rf_we, rf_waddr, rf_wdata, pend_mask, conflict_cnt
  );
  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input alu_ready, mem_ready, rf_we, rf_waddr, rf_wdata, pend_mask, conflict_cnt
  );
endinterface

// File: rtl/regfile_wb_arbiter_wb_slot.sv
// regfile_wb_arbiter_wb_slot: one-entry writeback holding slot; drops x0 requests, exports one-hot rd
module regfile_wb_arbiter_wb_slot
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int AW = AW_DEF
) (
  input  logic Clk,
  input  logic Reset,
  input  logic valid_i,
  input  logic [AW-1:0] rd_i,
  input  logic [XLEN-1:0] data_i,
  input  logic grant_i,
  output logic ready_o,
  output logic load_o,
  output logic held_nxt_o,
  output logic [AW-1:0] rd_o,
  output logic [XLEN-1:0] data_o,
  output logic [(1<<AW)-1:0] onehot_o
);
  localparam int NR = 1 << AW;
  logic held_q;
  logic [AW-1:0] rd_q;
  logic [XLEN-1:0] data_q;
  logic drop;
  always_comb begin
    ready_o = !held_q || grant_i;
    drop = rd_i == AW'(X0);
    load_o = valid_i && ready_o && !drop;
    held_nxt_o = load_o || (held_q && !grant_i);
    onehot_o = held_q ? NR'(1) << rd_q : '0;
  end
  assign rd_o = rd_q;
  assign data_o = data_q;
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      held_q <= 1'b0;
      rd_q <= '0;
      data_q <= '0;
    end else begin
      held_q <= held_nxt_o;
      if (load_o) begin
        rd_q <= rd_i;
        data_q <= data_i;
      end
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: age-ordered arbitration of ALU and load writebacks onto the single register-file write port
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int AW = AW_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic Clk,
  input logic Reset,
  regfile_wb_arbiter_if.slave bus
);
  localparam int NR = 1 << AW;
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic alu_grant, mem_grant, both;
  logic alu_load, mem_load, alu_nxt, mem_nxt;
  logic [AW-1:0] alu_rd_q, mem_rd_q;
  logic [XLEN-1:0] alu_data_q, mem_data_q;
  logic [NR-1:0] alu_oh, mem_oh;
  regfile_wb_arbiter_wb_slot #(.XLEN(XLEN), .AW(AW)) u_alu (
    .Clk(Clk), .Reset(Reset), .valid_i(bus.alu_valid), .rd_i(bus.alu_rd), .data_i(bus.alu_data),
    .grant_i(alu_grant), .ready_o(bus.alu_ready), .load_o(alu_load), .held_nxt_o(alu_nxt),
    .rd_o(alu_rd_q), .data_o(alu_data_q), .onehot_o(alu_oh)
  );
  regfile_wb_arbiter_wb_slot #(.XLEN(XLEN), .AW(AW)) u_mem (
    .Clk(Clk), .Reset(Reset), .valid_i(bus.mem_valid), .rd_i(bus.mem_rd), .data_i(bus.mem_data),
    .grant_i(mem_grant), .ready_o(bus.mem_ready), .load_o(mem_load), .held_nxt_o(mem_nxt),
    .rd_o(mem_rd_q), .data_o(mem_data_q), .onehot_o(mem_oh)
  );
  // When both end up held, a freshly loaded entry is younger; a simultaneous double load favours the load slot.
  always_comb begin
    alu_grant = state_q == A_ONLY || state_q == BOTH_AF;
    mem_grant = state_q == M_ONLY || state_q == BOTH_MF;
    both = state_q == BOTH_AF || state_q == BOTH_MF;
    state_d = !alu_nxt && !mem_nxt ? IDLE :
              !mem_nxt ? A_ONLY :
              !alu_nxt ? M_ONLY :
              alu_load ? BOTH_MF :
              mem_load ? BOTH_AF : state_q;
    cnt_d = both && cnt_q != '1 ? cnt_q + 1'b1 : cnt_q;
  end
  assign bus.rf_we = alu_grant || mem_grant;
  assign bus.rf_waddr = alu_grant ? alu_rd_q : mem_grant ? mem_rd_q : '0;
  assign bus.rf_wdata = alu_grant ? alu_data_q : mem_grant ? mem_data_q : '0;
  assign bus.pend_mask = alu_oh | mem_oh;
  assign bus.conflict_cnt = cnt_q;
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed checks of the writeback arbiter against a register-file model
module tb_regfile_wb_arbiter;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  int w0;
  logic [31:0] rf [32];
  regfile_wb_arbiter_if ifc ();
  regfile_wb_arbiter dut (.Clk(Clk), .Reset(Reset), .bus(ifc));
  always #5 Clk = ~Clk;
  always @(posedge Clk) begin
    if (ifc.rf_we === 1'b1) begin
      wr_cnt++;
      if (ifc.rf_waddr != 0) rf[ifc.rf_waddr] = ifc.rf_wdata;
    end
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge Clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    int na, nm, la, lm, ga, gm, nwe;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    ifc.alu_valid = 0; ifc.alu_rd = 0; ifc.alu_data = 0;
    ifc.mem_valid = 0; ifc.mem_rd = 0; ifc.mem_data = 0;
    #1;
    chk("rst_we", ifc.rf_we, 0);
    chk("rst_waddr", ifc.rf_waddr, 0);
    chk("rst_wdata", ifc.rf_wdata, 0);
    chk("rst_alu_ready", ifc.alu_ready, 1);
    chk("rst_mem_ready", ifc.mem_ready, 1);
    chk("rst_pend", ifc.pend_mask, 0);
    chk("rst_cnt", ifc.conflict_cnt, 0);
    step(); step();
    Reset = 0;
    step();
    // single uncontended ALU write
    ifc.alu_valid = 1; ifc.alu_rd = 1; ifc.alu_data = 123;
    step();
    ifc.alu_valid = 0;
    chk("t1_we", ifc.rf_we, 1);
    chk("t1_waddr", ifc.rf_waddr, 1);
    chk("t1_wdata", ifc.rf_wdata, 123);
    chk("t1_pend", ifc.pend_mask, 32'h2);
    step();
    chk("t1_we_off", ifc.rf_we, 0);
    chk("t1_pend_off", ifc.pend_mask, 0);
    chk("t1_rf1", rf[1], 123);
    // simultaneous arrival: load treated as older
    ifc.alu_valid = 1; ifc.alu_rd = 2; ifc.alu_data = 456;
    ifc.mem_valid = 1; ifc.mem_rd = 3; ifc.mem_data = 789;
    step();
    ifc.alu_valid = 0; ifc.mem_valid = 0;
    chk("t2_first_waddr", ifc.rf_waddr, 3);
    chk("t2_first_wdata", ifc.rf_wdata, 789);
    chk("t2_pend_both", ifc.pend_mask, 32'hC);
    chk("t2_mem_ready", ifc.mem_ready, 1);
    step();
    chk("t2_second_waddr", ifc.rf_waddr, 2);
    chk("t2_second_wdata", ifc.rf_wdata, 456);
    chk("t2_pend_alu", ifc.pend_mask, 32'h4);
    chk("t2_cnt", ifc.conflict_cnt, 1);
    step();
    chk("t2_we_off", ifc.rf_we, 0);
    chk("t2_rf2", rf[2], 456);
    chk("t2_rf3", rf[3], 789);
    chk("t2_ready_after", {ifc.alu_ready, ifc.mem_ready}, 2'b11);
    // same rd, ALU older, ALU stream continues
    ifc.alu_valid = 1; ifc.alu_rd = 5; ifc.alu_data = 32'hAAAA;
    step();
    ifc.alu_rd = 6; ifc.alu_data = 32'h66;
    ifc.mem_valid = 1; ifc.mem_rd = 5; ifc.mem_data = 32'hBBBB;
    chk("t3_w1_addr", ifc.rf_waddr, 5);
    chk("t3_w1_data", ifc.rf_wdata, 32'hAAAA);
    chk("t3_alu_ready_refill", ifc.alu_ready, 1);
    step();
    ifc.mem_valid = 0;
    ifc.alu_rd = 7; ifc.alu_data = 32'h77;
    chk("t3_w2_addr", ifc.rf_waddr, 5);
    chk("t3_w2_data", ifc.rf_wdata, 32'hBBBB);
    chk("t3_alu_stall", ifc.alu_ready, 0);
    chk("t3_pend", ifc.pend_mask, 32'h60);
    step();
    chk("t3_w3_addr", ifc.rf_waddr, 6);
    chk("t3_w3_data", ifc.rf_wdata, 32'h66);
    chk("t3_alu_ready", ifc.alu_ready, 1);
    step();
    ifc.alu_valid = 0;
    chk("t3_w4_addr", ifc.rf_waddr, 7);
    chk("t3_w4_data", ifc.rf_wdata, 32'h77);
    step();
    chk("t3_we_off", ifc.rf_we, 0);
    chk("t3_rf5", rf[5], 32'hBBBB);
    chk("t3_cnt", ifc.conflict_cnt, 2);
    // x0 request is accepted and dropped
    w0 = wr_cnt;
    ifc.alu_valid = 1; ifc.alu_rd = 0; ifc.alu_data = 789;
    chk("t4_ready", ifc.alu_ready, 1);
    step();
    ifc.alu_valid = 0;
    chk("t4_we", ifc.rf_we, 0);
    chk("t4_pend", ifc.pend_mask, 0);
    step();
    chk("t4_no_write", wr_cnt, w0);
    // both sources streaming for 100 cycles
    na = 0; nm = 0; la = -1; lm = -1; ga = 0; gm = 0; nwe = 0;
    for (int i = 0; i < 100; i++) begin
      ifc.alu_valid = 1; ifc.alu_rd = 5'(8 + i % 4); ifc.alu_data = i;
      ifc.mem_valid = 1; ifc.mem_rd = 5'(16 + i % 4); ifc.mem_data = 1000 + i;
      step();
      if (ifc.rf_we === 1'b1) nwe++;
      if (ifc.rf_we === 1'b1 && ifc.rf_waddr >= 8 && ifc.rf_waddr <= 11) begin
        na++; if (i - la > ga) ga = i - la; la = i;
      end
      if (ifc.rf_we === 1'b1 && ifc.rf_waddr >= 16 && ifc.rf_waddr <= 19) begin
        nm++; if (i - lm > gm) gm = i - lm; lm = i;
      end
    end
    ifc.alu_valid = 0; ifc.mem_valid = 0;
    chk("t5_we_every_cycle", nwe, 100);
    chk("t5_alu_grants", na, 50);
    chk("t5_mem_grants", nm, 50);
    chk("t5_alu_gap_le2", ga <= 2, 1);
    chk("t5_mem_gap_le2", gm <= 2, 1);
    chk("t5_cnt", ifc.conflict_cnt, 2 + 99);
    step(); step(); step();
    chk("t5_drained", ifc.rf_we, 0);
    // async reset while both slots are held
    ifc.alu_valid = 1; ifc.alu_rd = 12; ifc.alu_data = 32'h1212;
    ifc.mem_valid = 1; ifc.mem_rd = 13; ifc.mem_data = 32'h1313;
    step();
    ifc.alu_valid = 0; ifc.mem_valid = 0;
    chk("t6_tie_mem_first", ifc.rf_waddr, 13);
    chk("t6_pend", ifc.pend_mask, 32'h3000);
    #3;
    Reset = 1;
    #1;
    w0 = wr_cnt;
    chk("t6_we", ifc.rf_we, 0);
    chk("t6_waddr", ifc.rf_waddr, 0);
    chk("t6_wdata", ifc.rf_wdata, 0);
    chk("t6_pend_clr", ifc.pend_mask, 0);
    chk("t6_cnt_clr", ifc.conflict_cnt, 0);
    chk("t6_ready", {ifc.alu_ready, ifc.mem_ready}, 2'b11);
    @(posedge Clk);
    #2;
    Reset = 0;
    step(); step(); step();
    chk("t6_no_write", wr_cnt, w0);
    chk("t6_rf12", rf[12], 0);
    chk("t6_rf13", rf[13], 0);
    chk("t6_idle", ifc.rf_we, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
